// File: rtl/round_key_store.sv
// round_key_store: holds an expanded round-key schedule (rounds 0..Nr) and streams it to the cipher core.
// Latency: start accepted on edge N shows the first key right after edge N, then one key per cycle.
// Backpressure: key_ready low holds key_data/key_round/key_last; start only accepted when idle with a full schedule.
module round_key_store #(
  parameter int KEY_S  = 128,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [KEY_S-1:0]  wr_data,
  input  logic              wr_done,
  input  logic [ADDR_W-1:0] rounds_total,
  input  logic              start,
  input  logic              decrypt,
  output logic              start_ready,
  output logic              sched_valid,
  output logic [KEY_S-1:0]  key_data,
  output logic [ADDR_W-1:0] key_round,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_last,
  output logic              aborted
);

  localparam logic [ADDR_W-1:0] NR_MAX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] NR_MIN = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t            state, state_d;
  logic [KEY_S-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] nr_q, nr_clamped;
  logic              dir, dir_d;
  logic [ADDR_W-1:0] key_round_d;
  logic              key_valid_d, key_last_d, aborted_d, load_key;
  logic              wr_zero, start_acc;

  // A write to round 0 marks the start of a fresh schedule.
  assign wr_zero     = wr_en && (wr_addr == '0);
  assign start_ready = (state == IDLE) && sched_valid;
  // A simultaneous round-0 write invalidates the schedule, so start is dropped.
  assign start_acc   = start && start_ready && !wr_zero;

  // Clamp the advertised round count into the range the storage can hold.
  always_comb begin
    nr_clamped = rounds_total;
    if (rounds_total > NR_MAX) nr_clamped = NR_MAX;
    else if (rounds_total < NR_MIN) nr_clamped = NR_MIN;
  end

  // Key storage: not reset, out-of-range addresses ignored.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr <= NR_MAX)) mem[wr_addr] <= wr_data;
  end

  // Schedule-complete flag and latched round count; wr_done beats a round-0 clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sched_valid <= 1'b0;
      nr_q        <= NR_MAX;
    end else if (wr_done) begin
      sched_valid <= 1'b1;
      nr_q        <= nr_clamped;
    end else if (wr_zero) begin
      sched_valid <= 1'b0;
    end
  end

  // Next-state and next-output logic for the streaming FSM.
  always_comb begin
    state_d     = state;
    dir_d       = dir;
    key_round_d = key_round;
    key_valid_d = key_valid;
    key_last_d  = key_last;
    aborted_d   = 1'b0;
    load_key    = 1'b0;
    case (state)
      IDLE: begin
        if (start_acc) begin
          state_d     = STREAM;
          dir_d       = decrypt;
          key_round_d = decrypt ? nr_q : '0;
          key_valid_d = 1'b1;
          key_last_d  = decrypt ? (nr_q == '0) : (nr_q == '0);
          load_key    = 1'b1;
        end
      end
      STREAM: begin
        if (wr_zero) begin
          // New schedule arriving: cancel the stream; a handshake this cycle still counts.
          state_d     = IDLE;
          key_valid_d = 1'b0;
          key_last_d  = 1'b0;
          aborted_d   = 1'b1;
        end else if (key_valid && key_ready) begin
          if (key_last) begin
            state_d     = IDLE;
            key_valid_d = 1'b0;
            key_last_d  = 1'b0;
          end else begin
            key_round_d = dir ? (key_round - STEP) : (key_round + STEP);
            key_last_d  = dir ? (key_round_d == '0) : (key_round_d == nr_q);
            load_key    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and output registers; key_data is fetched on the same edge the index moves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      dir       <= 1'b0;
      key_round <= '0;
      key_data  <= '0;
      key_valid <= 1'b0;
      key_last  <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_d;
      dir       <= dir_d;
      key_round <= key_round_d;
      key_valid <= key_valid_d;
      key_last  <= key_last_d;
      aborted   <= aborted_d;
      if (load_key) key_data <= mem[key_round_d];
    end
  end

endmodule

// File: tb/tb_round_key_store.sv
// Bench for round_key_store: scoreboard of expected keys filled at start, popped on each handshake.
module tb_round_key_store;
  localparam int KEY_S  = 128;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 15;

  typedef struct packed {
    logic [ADDR_W-1:0] round;
    logic [KEY_S-1:0]  data;
    logic              last;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [KEY_S-1:0]  wr_data;
  logic              wr_done;
  logic [ADDR_W-1:0] rounds_total;
  logic              start;
  logic              decrypt;
  logic              start_ready;
  logic              sched_valid;
  logic [KEY_S-1:0]  key_data;
  logic [ADDR_W-1:0] key_round;
  logic              key_valid;
  logic              key_ready;
  logic              key_last;
  logic              aborted;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  round_key_store #(.KEY_S(KEY_S), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .rounds_total(rounds_total),
    .start(start), .decrypt(decrypt), .start_ready(start_ready),
    .sched_valid(sched_valid), .key_data(key_data), .key_round(key_round),
    .key_valid(key_valid), .key_ready(key_ready), .key_last(key_last),
    .aborted(aborted)
  );

  always #5 clk = ~clk;

  function automatic logic [KEY_S-1:0] key_of(input int a);
    logic [3:0] n;
    n = 4'(a);
    return {32{n}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_done = 0; rounds_total = '0;
    start = 0; decrypt = 0;
  endtask

  task automatic write_key(input int a, input bit done, input int nr);
    wr_en = 1; wr_addr = ADDR_W'(a); wr_data = key_of(a);
    wr_done = done; rounds_total = ADDR_W'(nr);
    tick();
    wr_en = 0; wr_done = 0;
  endtask

  task automatic push_exp(input bit dec, input int nr);
    int r;
    sb.delete();
    for (int i = 0; i <= nr; i++) begin
      r = dec ? nr - i : i;
      sb.push_back('{round: ADDR_W'(r), data: key_of(r), last: (i == nr)});
    end
  endtask

  task automatic test_reset();
    reset = 0; key_ready = 0; idle_inputs();
    #23;
    vectors++;
    if ({sched_valid, key_valid, key_last, aborted, start_ready} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 00000", {sched_valid, key_valid, key_last, aborted, start_ready});
    end
    vectors++;
    if (key_round !== '0 || key_data !== '0) begin
      miscompares++;
      $display("FAIL reset_key got r=%0d d=%h want 0/0", key_round, key_data);
    end
    reset = 1;
    tick();
    vectors++;
    if (sched_valid !== 1'b0 || start_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset got sv=%b sr=%b want 0/0", sched_valid, start_ready);
    end
  endtask

  task automatic test_load();
    for (int a = 0; a <= 10; a++) begin
      write_key(a, a == 10, 10);
      if (a == 0) begin
        vectors++;
        if (sched_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL load_partial got sv=%b want 0", sched_valid);
        end
      end
    end
    vectors++;
    if (sched_valid !== 1'b1 || start_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_done got sv=%b sr=%b want 1/1", sched_valid, start_ready);
    end
  endtask

  task automatic test_encrypt();
    exp_t e;
    int iter = 0;
    push_exp(0, 10);
    start = 1; decrypt = 0; key_ready = 1;
    tick();
    start = 0;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      iter++;
      if (key_valid) begin
        e = sb.pop_front();
        vectors++;
        if ({key_round, key_data, key_last} !== e) begin
          miscompares++;
          $display("FAIL enc_key got r=%0d last=%b d=%h want r=%0d last=%b d=%h",
                   key_round, key_last, key_data, e.round, e.last, e.data);
        end
      end
      tick();
    end
    vectors++;
    if (sb.size() != 0 || iter != 11) begin
      miscompares++;
      $display("FAIL enc_cycles got %0d cycles, %0d left want 11 cycles, 0 left", iter, sb.size());
    end
    vectors++;
    if (key_valid !== 1'b0 || start_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL enc_end got kv=%b sr=%b want 0/1", key_valid, start_ready);
    end
  endtask

  task automatic test_decrypt_backpressure();
    int vcyc = 0;
    for (int a = 0; a <= 14; a++) write_key(a, a == 14, 14);
    push_exp(1, 14);
    start = 1; decrypt = 1; key_ready = 1;
    tick();
    start = 0; decrypt = 0;
    for (int c = 0; c < 80 && sb.size() > 0; c++) begin
      key_ready = (c % 2 == 0);
      if (key_valid) begin
        vcyc++;
        vectors++;
        if ({key_round, key_data, key_last} !== sb[0]) begin
          miscompares++;
          $display("FAIL dec_key got r=%0d last=%b d=%h want r=%0d last=%b d=%h",
                   key_round, key_last, key_data, sb[0].round, sb[0].last, sb[0].data);
        end
        if (key_ready) void'(sb.pop_front());
      end
      tick();
    end
    vectors++;
    if (sb.size() != 0 || vcyc != 29 || key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dec_cycles got %0d valid cycles, %0d left, kv=%b want 29, 0, 0", vcyc, sb.size(), key_valid);
    end
  endtask

  task automatic test_ignored_start();
    exp_t e;
    int seen = 0;
    key_ready = 1;
    for (int a = 0; a <= 3; a++) write_key(a, 1'b0, 10);
    vectors++;
    if (sched_valid !== 1'b0 || start_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL early_start_ready got sv=%b sr=%b want 0/0", sched_valid, start_ready);
    end
    start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 3; c++) begin
      if (key_valid) seen++;
      tick();
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL early_start got %0d valid cycles want 0", seen);
    end
    for (int a = 4; a <= 10; a++) write_key(a, a == 10, 10);
    key_ready = 0; start = 1; decrypt = 0;
    tick();
    start = 0;
    vectors++;
    if (start_ready !== 1'b0 || key_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stream_busy got sr=%b kv=%b want 0/1", start_ready, key_valid);
    end
    start = 1; decrypt = 1;
    tick();
    tick();
    start = 0; decrypt = 0;
    vectors++;
    if (key_valid !== 1'b1 || key_round !== 4'd0 || key_data !== key_of(0)) begin
      miscompares++;
      $display("FAIL stall_hold got kv=%b r=%0d want 1/0", key_valid, key_round);
    end
    push_exp(0, 10);
    key_ready = 1;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      if (key_valid) begin
        e = sb.pop_front();
        vectors++;
        if ({key_round, key_data, key_last} !== e) begin
          miscompares++;
          $display("FAIL busy_key got r=%0d last=%b want r=%0d last=%b", key_round, key_last, e.round, e.last);
        end
      end
      tick();
    end
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      if (key_valid) seen++;
      tick();
    end
    vectors++;
    if (sb.size() != 0 || seen != 0 || start_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_end got left=%0d extra=%0d sr=%b want 0/0/1", sb.size(), seen, start_ready);
    end
  endtask

  task automatic test_abort();
    exp_t e;
    bit hit = 0;
    push_exp(0, 10);
    key_ready = 1; start = 1; decrypt = 0;
    tick();
    start = 0;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      if (key_valid) begin
        e = sb.pop_front();
        vectors++;
        if ({key_round, key_data, key_last} !== e) begin
          miscompares++;
          $display("FAIL abort_key got r=%0d last=%b want r=%0d last=%b", key_round, key_last, e.round, e.last);
        end
        if (e.round == 4'd4) begin
          hit = 1;
          wr_en = 1; wr_addr = '0; wr_data = key_of(0);
          tick();
          wr_en = 0;
          break;
        end
      end
      tick();
    end
    vectors++;
    if (!hit || {key_valid, key_last, aborted, sched_valid, start_ready} !== 5'b00100) begin
      miscompares++;
      $display("FAIL abort_pulse got hit=%b kv,kl,ab,sv,sr=%b want 1 00100", hit,
               {key_valid, key_last, aborted, sched_valid, start_ready});
    end
    tick();
    tick();
    vectors++;
    if (aborted !== 1'b0 || sched_valid !== 1'b0 || key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_after got ab=%b sv=%b kv=%b want 0/0/0", aborted, sched_valid, key_valid);
    end
    sb.delete();
  endtask

  task automatic test_async_reset_clamp();
    exp_t e;
    int iter = 0;
    for (int a = 0; a <= 10; a++) write_key(a, a == 10, 10);
    key_ready = 1; start = 1; decrypt = 0;
    tick();
    start = 0;
    tick();
    tick();
    #2 reset = 0;
    #1;
    vectors++;
    if ({key_valid, sched_valid, key_last, start_ready, aborted} !== 5'b00000 || key_round !== '0) begin
      miscompares++;
      $display("FAIL async_reset got kv,sv,kl,sr,ab=%b r=%0d want 00000 r=0",
               {key_valid, sched_valid, key_last, start_ready, aborted}, key_round);
    end
    reset = 1;
    tick();
    for (int a = 0; a <= 14; a++) write_key(a, a == 14, 15);
    push_exp(0, 14);
    start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      iter++;
      if (key_valid) begin
        e = sb.pop_front();
        vectors++;
        if ({key_round, key_data, key_last} !== e) begin
          miscompares++;
          $display("FAIL clamp_hi_key got r=%0d last=%b want r=%0d last=%b", key_round, key_last, e.round, e.last);
        end
      end
      tick();
    end
    vectors++;
    if (sb.size() != 0 || iter != 15 || key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clamp_hi_len got %0d cycles, %0d left want 15, 0", iter, sb.size());
    end
  endtask

  task automatic test_clamp_low();
    exp_t e;
    int iter = 0;
    for (int a = 0; a <= 1; a++) write_key(a, a == 1, 0);
    push_exp(0, 1);
    key_ready = 1; start = 1; decrypt = 0;
    tick();
    start = 0;
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      iter++;
      if (key_valid) begin
        e = sb.pop_front();
        vectors++;
        if ({key_round, key_data, key_last} !== e) begin
          miscompares++;
          $display("FAIL clamp_lo_key got r=%0d last=%b want r=%0d last=%b", key_round, key_last, e.round, e.last);
        end
      end
      tick();
    end
    vectors++;
    if (sb.size() != 0 || iter != 2 || key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clamp_lo_len got %0d cycles, %0d left want 2, 0", iter, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_encrypt();
    test_decrypt_backpressure();
    test_ignored_start();
    test_abort();
    test_async_reset_clamp();
    test_clamp_low();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
